// File: rtl/updown_counter_pkg.sv
// Shared types and elaboration-time helpers for the up/down counter bank.
//   cnt_op_e    : per-channel decoded operation for one cycle.
//   arith_width : width used for value+step arithmetic so intermediate sums never overflow.
//   range_of    : number of distinct values between the bounds (modulus in wrap mode).
// Optional feature macro used by the users of this package: UPDOWN_COUNTER_STICKY_EN.
package updown_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } cnt_op_e;

  // One guard bit above value+step keeps both sums and the sign of differences visible.
  localparam int unsigned ArithGuardBits = 1;

  function automatic int unsigned arith_width(int unsigned width, int unsigned step_w);
    return width + step_w + ArithGuardBits;
  endfunction

  function automatic int unsigned range_of(int unsigned min_val, int unsigned max_val);
    return max_val - min_val + 1;
  endfunction

endpackage

// File: rtl/updown_counter_ch.sv
// One bounded up/down counter channel: operation decode, step arithmetic with clamp or wrap,
// value register, bound flags and registered overflow/underflow pulses.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   load_i, load_val_i  : load strobe and value (clamped into [MIN_VAL, MAX_VAL])
//   inc_i, dec_i        : step requests; both high or step_i == 0 means hold
//   step_i              : step magnitude
//   value_o             : registered counter value
//   at_min_o, at_max_o  : value_o sits on a bound
//   over_o, under_o     : one-cycle pulse, visible together with the updated value
//   clear_sticky_i, sticky_o : only with UPDOWN_COUNTER_STICKY_EN; latched event flag
module updown_counter_ch
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned MIN_VAL  = 0,
  parameter int unsigned MAX_VAL  = 99,
  parameter int unsigned INIT_VAL = 0,
  parameter bit          WRAP     = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_val_i,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic [STEP_W-1:0] step_i,
`ifdef UPDOWN_COUNTER_STICKY_EN
  input  logic              clear_sticky_i,
  output logic              sticky_o,
`endif
  output logic [WIDTH-1:0]  value_o,
  output logic              at_min_o,
  output logic              at_max_o,
  output logic              over_o,
  output logic              under_o
);

  localparam int unsigned      AW     = arith_width(WIDTH, STEP_W);
  localparam logic [AW-1:0]    MinA   = AW'(MIN_VAL);
  localparam logic [AW-1:0]    RangeA = AW'(range_of(MIN_VAL, MAX_VAL));
  localparam logic [AW-1:0]    SpanA  = AW'(MAX_VAL - MIN_VAL);
  localparam logic [WIDTH-1:0] MinV   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MaxV   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] InitV  = WIDTH'(INIT_VAL);

  cnt_op_e          op;
  logic [AW-1:0]    off_a;    // current value relative to MIN_VAL
  logic [AW-1:0]    step_a;
  logic [AW-1:0]    step_r;   // step reduced modulo the range
  logic [AW-1:0]    sum_a;    // offset after an increment
  logic [AW-1:0]    lv_off;   // load value relative to MIN_VAL; MSB set when below MIN_VAL
  logic [WIDTH-1:0] value_d, value_q;
  logic             over_d, over_q;
  logic             under_d, under_q;

  always_comb begin
    op = OP_HOLD;
    if (load_i) begin
      op = OP_LOAD;
    end else if ((inc_i ^ dec_i) && (step_i != '0)) begin
      op = inc_i ? OP_INC : OP_DEC;
    end
  end

  always_comb begin
    off_a   = AW'(value_q) - MinA;
    step_a  = AW'(step_i);
    step_r  = step_a % RangeA;
    sum_a   = off_a + step_a;
    lv_off  = AW'(load_val_i) - MinA;
    value_d = value_q;
    over_d  = 1'b0;
    under_d = 1'b0;

    unique case (op)
      OP_LOAD: begin
        if (lv_off[AW-1]) begin
          value_d = MinV;
        end else if (lv_off > SpanA) begin
          value_d = MaxV;
        end else begin
          value_d = WIDTH'(MinA + lv_off);
        end
      end
      OP_INC: begin
        if (sum_a > SpanA) begin
          over_d  = 1'b1;
          value_d = WRAP ? WIDTH'(MinA + (sum_a % RangeA)) : MaxV;
        end else begin
          value_d = WIDTH'(MinA + sum_a);
        end
      end
      OP_DEC: begin
        if (step_a > off_a) begin
          under_d = 1'b1;
          // Adding the range before subtracting keeps the wrapped offset non-negative.
          value_d = WRAP ? WIDTH'(MinA + ((off_a + RangeA - step_r) % RangeA)) : MinV;
        end else begin
          value_d = WIDTH'(MinA + off_a - step_a);
        end
      end
      default: value_d = value_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= InitV;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      value_q <= value_d;
      over_q  <= over_d;
      under_q <= under_d;
    end
  end

  assign value_o  = value_q;
  assign at_min_o = (value_q == MinV);
  assign at_max_o = (value_q == MaxV);
  assign over_o   = over_q;
  assign under_o  = under_q;

`ifdef UPDOWN_COUNTER_STICKY_EN
  logic sticky_d, sticky_q;

  // Set is taken from the next-state pulses so the flag rises with the pulse and wins a clear.
  always_comb begin
    sticky_d = sticky_q;
    if (clear_sticky_i) sticky_d = 1'b0;
    if (over_d || under_d) sticky_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_o = sticky_q;
`endif

endmodule

// File: rtl/updown_counter_bank.sv
// Bank of NUM_CH independent bounded up/down counters (scores, lives, timers).
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   load, load_val         : per-channel load strobe and value (channel i at [i*WIDTH +: WIDTH])
//   increase, decrease     : per-channel step requests
//   step                   : step magnitude shared by all channels
//   out                    : registered values, same packing as load_val
//   at_min, at_max         : per-channel bound flags
//   over_pulse, under_pulse: per-channel registered crossing pulses
//   clear_sticky, sticky_evt : only when UPDOWN_COUNTER_STICKY_EN is defined
module updown_counter_bank
  import updown_counter_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned MIN_VAL  = 0,
  parameter int unsigned MAX_VAL  = 99,
  parameter int unsigned INIT_VAL = 0,
  parameter bit          WRAP     = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [NUM_CH-1:0]       increase,
  input  logic [NUM_CH-1:0]       decrease,
  input  logic [STEP_W-1:0]       step,
`ifdef UPDOWN_COUNTER_STICKY_EN
  input  logic [NUM_CH-1:0]       clear_sticky,
  output logic [NUM_CH-1:0]       sticky_evt,
`endif
  output logic [NUM_CH*WIDTH-1:0] out,
  output logic [NUM_CH-1:0]       at_min,
  output logic [NUM_CH-1:0]       at_max,
  output logic [NUM_CH-1:0]       over_pulse,
  output logic [NUM_CH-1:0]       under_pulse
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    updown_counter_ch #(
      .WIDTH    (WIDTH),
      .STEP_W   (STEP_W),
      .MIN_VAL  (MIN_VAL),
      .MAX_VAL  (MAX_VAL),
      .INIT_VAL (INIT_VAL),
      .WRAP     (WRAP)
    ) u_ch (
      .clk_i          (clock),
      .rst_i          (reset),
      .load_i         (load[i]),
      .load_val_i     (load_val[i*WIDTH +: WIDTH]),
      .inc_i          (increase[i]),
      .dec_i          (decrease[i]),
      .step_i         (step),
`ifdef UPDOWN_COUNTER_STICKY_EN
      .clear_sticky_i (clear_sticky[i]),
      .sticky_o       (sticky_evt[i]),
`endif
      .value_o        (out[i*WIDTH +: WIDTH]),
      .at_min_o       (at_min[i]),
      .at_max_o       (at_max[i]),
      .over_o         (over_pulse[i]),
      .under_o        (under_pulse[i])
    );
  end

endmodule
